qrs_peak_detector: RTL and testbench

//  Consumes the 32-bit multiscale-product stream MPavg produced by the wavelet product/averaging stage.

---
 rtl/qrs_pkg.sv | 18 +
 rtl/qrs_thr_tracker.sv | 54 +++++
 rtl/qrs_peak_detector.sv | 143 ++++++++++++++
 tb/tb_qrs_peak_detector.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qrs_pkg.sv
// rtl/qrs_pkg.sv - shared state encoding and default parameters for the QRS peak detector
package qrs_pkg;

   localparam int QRS_DATA_W      = 32;
   localparam int QRS_IDX_W       = 16;
   localparam int QRS_LEARN_LEN   = 512;
   localparam int QRS_REFRACT_LEN = 72;
   localparam int QRS_MAX_WIDTH   = 36;
   localparam int QRS_THR_MIN     = 64;

   typedef enum logic [1:0] {
      ST_LEARN,
      ST_SEARCH,
      ST_TRACK,
      ST_REFRACT
   } state_t;

endpackage

// File: rtl/qrs_thr_tracker.sv
// rtl/qrs_thr_tracker.sv - learned peak level (max during LEARN, 1/8 IIR per beat) and clamped threshold
module qrs_thr_tracker
   import qrs_pkg::*;
#(
   parameter int DATA_W  = QRS_DATA_W,
   parameter int THR_MIN = QRS_THR_MIN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              learn_en,
   input  logic              learn_last,
   input  logic [DATA_W-1:0] sample,
   input  logic              detect,
   input  logic [DATA_W-1:0] peak,
   output logic [DATA_W-1:0] thr
);

   localparam logic [DATA_W-1:0] THR_FLOOR = DATA_W'(THR_MIN);

   logic [DATA_W-1:0] pkl;
   logic [DATA_W-1:0] learn_max;
   logic [DATA_W-1:0] pkl_eighth;
   logic [DATA_W-1:0] peak_eighth;
   logic [DATA_W:0]   pkl_sum;
   logic [DATA_W-1:0] pkl_new;

   function automatic logic [DATA_W-1:0] clamp_thr(input logic [DATA_W-1:0] level);
      return ((level >> 1) < THR_FLOOR) ? THR_FLOOR : (level >> 1);
   endfunction

   assign learn_max   = (sample > pkl) ? sample : pkl;
   assign pkl_eighth  = pkl >> 3;
   assign peak_eighth = peak >> 3;

   // pkl - pkl/8 + peak/8 cannot exceed full scale; the carry check is a safety net only
   assign pkl_sum = {1'b0, pkl} - {1'b0, pkl_eighth} + {1'b0, peak_eighth};
   assign pkl_new = pkl_sum[DATA_W] ? '1 : pkl_sum[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkl <= '0;
         thr <= THR_FLOOR;
      end else if (detect) begin
         pkl <= pkl_new;
         thr <= clamp_thr(pkl_new);
      end else if (learn_en) begin
         pkl <= learn_max;
         if (learn_last) begin
            thr <= clamp_thr(learn_max);
         end
      end
   end

endmodule

// File: rtl/qrs_peak_detector.sv
// rtl/qrs_peak_detector.sv - QRS beat detector: FSM, sample/width/refractory counters and beat outputs
module qrs_peak_detector
   import qrs_pkg::*;
#(
   parameter int DATA_W      = QRS_DATA_W,
   parameter int IDX_W       = QRS_IDX_W,
   parameter int LEARN_LEN   = QRS_LEARN_LEN,
   parameter int REFRACT_LEN = QRS_REFRACT_LEN,
   parameter int MAX_WIDTH   = QRS_MAX_WIDTH,
   parameter int THR_MIN     = QRS_THR_MIN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mp_valid,
   input  logic [DATA_W-1:0] mp_data,
   output logic              qrs_valid,
   output logic [DATA_W-1:0] qrs_amp,
   output logic [IDX_W-1:0]  qrs_idx,
   output logic [IDX_W-1:0]  rr_out,
   output logic              rr_ok,
   output logic [DATA_W-1:0] thr_out,
   output logic              learning
);

   localparam int CNT_W = $clog2(LEARN_LEN + REFRACT_LEN + MAX_WIDTH);
   localparam logic [CNT_W-1:0] LEARN_END   = CNT_W'(LEARN_LEN - 1);
   localparam logic [CNT_W-1:0] REFRACT_END = CNT_W'(REFRACT_LEN - 1);
   localparam logic [CNT_W-1:0] WIDTH_END   = CNT_W'(MAX_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [IDX_W-1:0]  samp_idx, cand_idx, cand_idx_nx, last_idx;
   logic [DATA_W-1:0] cand_amp, cand_amp_nx, thr;
   logic              first_beat, learn_en, learn_last, detect;

   // cnt is the learn count, the peak width or the refractory count depending on state
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      cand_amp_nx = cand_amp;
      cand_idx_nx = cand_idx;
      learn_en    = 1'b0;
      learn_last  = 1'b0;
      detect      = 1'b0;
      if (mp_valid) begin
         unique case (state)
            ST_LEARN: begin
               learn_en = 1'b1;
               cnt_nx   = cnt + 1'b1;
               if (cnt == LEARN_END) begin
                  learn_last = 1'b1;
                  cnt_nx     = '0;
                  state_nx   = ST_SEARCH;
               end
            end
            ST_SEARCH: begin
               if (mp_data > thr) begin
                  cand_amp_nx = mp_data;
                  cand_idx_nx = samp_idx;
                  cnt_nx      = CNT_ONE;
                  state_nx    = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (mp_data >= cand_amp) begin
                  cand_amp_nx = mp_data;
                  cand_idx_nx = samp_idx;
                  cnt_nx      = cnt + 1'b1;
                  detect      = (cnt == WIDTH_END);
               end else begin
                  detect = 1'b1;
               end
               if (detect) begin
                  cnt_nx   = '0;
                  state_nx = ST_REFRACT;
               end
            end
            ST_REFRACT: begin
               cnt_nx = cnt + 1'b1;
               if (cnt == REFRACT_END) begin
                  cnt_nx   = '0;
                  state_nx = ST_SEARCH;
               end
            end
            default: state_nx = ST_LEARN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_LEARN;
         cnt        <= '0;
         samp_idx   <= '0;
         cand_amp   <= '0;
         cand_idx   <= '0;
         last_idx   <= '0;
         first_beat <= 1'b1;
         qrs_valid  <= 1'b0;
         qrs_amp    <= '0;
         qrs_idx    <= '0;
         rr_out     <= '0;
         rr_ok      <= 1'b0;
      end else begin
         qrs_valid <= 1'b0;
         if (mp_valid) begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            cand_amp <= cand_amp_nx;
            cand_idx <= cand_idx_nx;
            samp_idx <= samp_idx + 1'b1;
         end
         if (detect) begin
            qrs_valid  <= 1'b1;
            qrs_amp    <= cand_amp_nx;
            qrs_idx    <= cand_idx_nx;
            rr_out     <= first_beat ? '0 : cand_idx_nx - last_idx;
            rr_ok      <= !first_beat;
            last_idx   <= cand_idx_nx;
            first_beat <= 1'b0;
         end
      end
   end

   qrs_thr_tracker #(
      .DATA_W  (DATA_W),
      .THR_MIN (THR_MIN)
   ) u_thr (
      .clk        (clk),
      .rst_n      (rst_n),
      .learn_en   (learn_en),
      .learn_last (learn_last),
      .sample     (mp_data),
      .detect     (detect),
      .peak       (cand_amp_nx),
      .thr        (thr)
   );

   assign thr_out  = thr;
   assign learning = (state == ST_LEARN);

endmodule

// File: tb/tb_qrs_peak_detector.sv
// tb/tb_qrs_peak_detector.sv - randomized scoreboard bench for qrs_peak_detector against a sample-level model
module tb_qrs_peak_detector;

   localparam int LEARN_LEN   = 512;
   localparam int REFRACT_LEN = 72;
   localparam int MAX_WIDTH   = 36;
   localparam int THR_MIN     = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mp_valid = 1'b0;
   logic [31:0] mp_data = '0;
   logic        qrs_valid, rr_ok, learning;
   logic [31:0] qrs_amp, thr_out;
   logic [15:0] qrs_idx, rr_out;

   qrs_peak_detector dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mp_valid  (mp_valid),
      .mp_data   (mp_data),
      .qrs_valid (qrs_valid),
      .qrs_amp   (qrs_amp),
      .qrs_idx   (qrs_idx),
      .rr_out    (rr_out),
      .rr_ok     (rr_ok),
      .thr_out   (thr_out),
      .learning  (learning)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   typedef struct {
      int     edge_n;
      longint amp;
      int     idx;
      int     rr;
      bit     rr_ok;
      longint thr;
   } beat_t;

   beat_t exp_q[$];

   // Sample-level behavioural model
   typedef enum {M_LEARN, M_SEARCH, M_TRACK, M_REFRACT} mmode_t;
   mmode_t m_mode;
   longint m_pkl, m_thr, m_cand;
   int     m_cidx, m_width, m_n, m_idx, m_last;
   bit     m_first;

   function automatic longint clampthr(input longint p);
      return (p / 2 < THR_MIN) ? longint'(THR_MIN) : p / 2;
   endfunction

   task automatic model_reset();
      m_mode  = M_LEARN;
      m_pkl   = 0;
      m_thr   = THR_MIN;
      m_cand  = 0;
      m_n     = 0;
      m_idx   = 0;
      m_last  = 0;
      m_first = 1;
      exp_q.delete();
   endtask

   task automatic model_beat(input int e);
      beat_t b;
      m_pkl = m_pkl - m_pkl / 8 + m_cand / 8;
      m_thr = clampthr(m_pkl);
      b.edge_n = e;
      b.amp    = m_cand;
      b.idx    = m_cidx;
      b.rr     = m_first ? 0 : (m_cidx - m_last + 65536) % 65536;
      b.rr_ok  = !m_first;
      b.thr    = m_thr;
      exp_q.push_back(b);
      m_last  = m_cidx;
      m_first = 0;
      m_mode  = M_REFRACT;
      m_n     = 0;
   endtask

   task automatic model_sample(input longint x, input int e);
      case (m_mode)
         M_LEARN: begin
            if (x > m_pkl) m_pkl = x;
            m_n++;
            if (m_n == LEARN_LEN) begin
               m_thr  = clampthr(m_pkl);
               m_mode = M_SEARCH;
            end
         end
         M_SEARCH: begin
            if (x > m_thr) begin
               m_cand = x; m_cidx = m_idx; m_width = 1; m_mode = M_TRACK;
            end
         end
         M_TRACK: begin
            if (x >= m_cand) begin
               m_cand = x; m_cidx = m_idx; m_width++;
               if (m_width == MAX_WIDTH) model_beat(e);
            end else begin
               model_beat(e);
            end
         end
         M_REFRACT: begin
            m_n++;
            if (m_n == REFRACT_LEN) m_mode = M_SEARCH;
         end
      endcase
      m_idx = (m_idx + 1) % 65536;
   endtask

   int gap_max = 0;

   // Called at posedge+1; the sample is consumed on the next rising edge
   task automatic send(input logic [31:0] x);
      mp_valid = 1'b1;
      mp_data  = x;
      model_sample(longint'(x), cyc + 1);
      @(posedge clk); #1;
      mp_valid = 1'b0;
      mp_data  = $urandom;
      if (gap_max > 0) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   beat_t mon_b;
   always @(negedge clk) begin
      if (rst_n && qrs_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: got strobe idx=%0d amp=%0d at cycle %0d, required none", qrs_idx, qrs_amp, cyc);
         end else begin
            mon_b = exp_q.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(mon_b.edge_n));
            chk("qrs_amp", 64'(qrs_amp), 64'(mon_b.amp));
            chk("qrs_idx", 64'(qrs_idx), 64'(mon_b.idx));
            chk("rr_out", 64'(rr_out), 64'(mon_b.rr));
            chk("rr_ok", 64'(rr_ok), 64'(mon_b.rr_ok));
            chk("thr_out", 64'(thr_out), 64'(mon_b.thr));
         end
      end
   end

   int cross_idx;
   int pend[$];

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_qrs_valid", 64'(qrs_valid), 0);
      chk("rst_qrs_amp", 64'(qrs_amp), 0);
      chk("rst_qrs_idx", 64'(qrs_idx), 0);
      chk("rst_rr_out", 64'(rr_out), 0);
      chk("rst_rr_ok", 64'(rr_ok), 0);
      chk("rst_learning", 64'(learning), 1);
      chk("rst_thr_out", 64'(thr_out), THR_MIN);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Learn: zeros with a single 1000
      gap_max = 2;
      for (int i = 0; i < LEARN_LEN; i++) begin
         if (i == LEARN_LEN - 1) chk("learning_before_end", 64'(learning), 1);
         send((i == 100) ? 32'd1000 : 32'd0);
      end
      chk("learning_after_learn", 64'(learning), 0);
      chk("thr_after_learn", 64'(thr_out), 500);

      // First beat
      gap_max = 1;
      send(0); send(600); send(800); send(700); send(0);
      chk("first_beat_amp", 64'(qrs_amp), 800);
      chk("first_beat_rr_ok", 64'(rr_ok), 0);
      chk("first_beat_thr", 64'(thr_out), 487);

      // Spike inside refractory window, then a second beat 300 samples later
      while (m_idx != 530) send(0);
      send(900);
      while (m_idx != 814) send(0);
      send(800); send(0);
      chk("second_beat_rr", 64'(rr_out), 300);
      chk("second_beat_rr_ok", 64'(rr_ok), 1);

      // Flat plateau forces detection at MAX_WIDTH
      while (m_mode != M_SEARCH) send(0);
      cross_idx = m_idx;
      repeat (40) send(700);
      while (m_mode != M_SEARCH) send(0);
      chk("forced_idx", 64'(qrs_idx), 64'(cross_idx + MAX_WIDTH - 1));
      chk("forced_amp", 64'(qrs_amp), 700);

      // Randomized pulses over noise
      gap_max = 2;
      for (int n = 0; n < 1500; n++) begin
         if (pend.size() == 0 && $urandom_range(0, 40) == 0) begin
            int a, l, plat;
            a = $urandom_range(100, 4000);
            l = $urandom_range(1, 5);
            plat = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 3);
            for (int k = 1; k <= l; k++) pend.push_back(a * k / l);
            repeat (plat) pend.push_back(a);
            for (int k = l - 1; k >= 0; k--) pend.push_back(a * k / l);
         end
         if (pend.size() > 0) send(32'(pend.pop_front()));
         else send(32'($urandom_range(0, 80)));
      end

      // Sample index wrap
      gap_max = 0;
      while (m_mode != M_SEARCH) send(0);
      while (m_idx != 65500) send(0);
      send(32'(m_thr + 500)); send(0);
      while (m_idx != 100) send(0);
      send(32'(m_thr + 500)); send(0);
      chk("wrap_rr", 64'(rr_out), 136);
      chk("wrap_rr_ok", 64'(rr_ok), 1);

      // Reset while tracking a candidate
      while (m_mode != M_SEARCH) send(0);
      send(32'(m_thr + 1000));
      chk("model_in_track", 64'(m_mode == M_TRACK), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_qrs_valid", 64'(qrs_valid), 0);
      chk("midrst_qrs_amp", 64'(qrs_amp), 0);
      chk("midrst_rr_out", 64'(rr_out), 0);
      chk("midrst_learning", 64'(learning), 1);
      chk("midrst_thr_out", 64'(thr_out), THR_MIN);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Relearn with a full-scale sample, then full-scale peaks
      gap_max = 1;
      for (int i = 0; i < LEARN_LEN; i++) send((i == 10) ? 32'hFFFF_FFFF : 32'd0);
      chk("fullscale_thr_learn", 64'(thr_out), 64'h7FFF_FFFF);
      repeat (5) begin
         while (m_mode != M_SEARCH) send(0);
         send(32'hFFFF_FFFF); send(0);
      end
      chk("fullscale_thr_beats", 64'(thr_out), 64'h7FFF_FFFF);
      chk("fullscale_amp", 64'(qrs_amp), 64'hFFFF_FFFF);

      repeat (3) @(posedge clk);
      #1;
      chk("pending_beats", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
